// File: rtl/cache_control.sv
// Two-way set-associative cache controller: hit check, dirty-victim writeback,
// line allocate from physical memory, and saturating hit/miss statistics.
module cache_control #(
  parameter int TAG_WIDTH = 9,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           mem_byte_enable,
  output logic                 mem_resp,
  input  logic [TAG_WIDTH-1:0] addr_tag,
  input  logic [TAG_WIDTH-1:0] tag0,
  input  logic [TAG_WIDTH-1:0] tag1,
  input  logic                 valid0,
  input  logic                 valid1,
  input  logic                 dirty0,
  input  logic                 dirty1,
  input  logic                 lru,
  output logic                 load_data0,
  output logic                 load_data1,
  output logic                 load_tag0,
  output logic                 load_tag1,
  output logic                 load_valid0,
  output logic                 load_valid1,
  output logic                 load_dirty0,
  output logic                 load_dirty1,
  output logic                 load_lru,
  output logic                 dirty_in,
  output logic                 lru_in,
  output logic                 datain_sel,
  output logic                 dataway_sel,
  output logic [1:0]           pmem_addr_sel,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_e;

  state_e               state_q, state_d;
  logic                 victim_q, victim_d;
  logic [CNT_WIDTH-1:0] hit_q, hit_d, miss_q, miss_d;

  logic hit0, hit1, hit, req, victim_sel, victim_dirty;
  logic [1:0] ld_data, ld_tag, ld_valid, ld_dirty;

  assign hit0         = valid0 && (tag0 == addr_tag);
  assign hit1         = valid1 && (tag1 == addr_tag);
  assign hit          = hit0 || hit1;
  assign req          = mem_read || mem_write;
  assign victim_sel   = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);
  assign victim_dirty = victim_sel ? (valid1 && dirty1) : (valid0 && dirty0);

  // Outputs are decoded only while out of reset so every port reads 0 during reset.
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    hit_d         = hit_q;
    miss_d        = miss_q;
    mem_resp      = 1'b0;
    ld_data       = '0;
    ld_tag        = '0;
    ld_valid      = '0;
    ld_dirty      = '0;
    load_lru      = 1'b0;
    dirty_in      = 1'b0;
    lru_in        = 1'b0;
    datain_sel    = 1'b0;
    dataway_sel   = 1'b0;
    pmem_addr_sel = 2'd0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        IDLE: if (req) state_d = CHECK;
        CHECK: begin
          if (!req) begin
            state_d = IDLE;
          end else if (hit) begin
            mem_resp    = 1'b1;
            dataway_sel = hit1;
            load_lru    = 1'b1;
            lru_in      = ~hit1;
            hit_d       = (hit_q == '1) ? hit_q : hit_q + CNT_WIDTH'(1);
            if (mem_write && (mem_byte_enable != 2'b00)) begin
              datain_sel = 1'b1;
              dirty_in   = 1'b1;
              ld_data    = hit1 ? 2'b10 : 2'b01;
              ld_dirty   = hit1 ? 2'b10 : 2'b01;
            end
            state_d = IDLE;
          end else begin
            miss_d   = (miss_q == '1) ? miss_q : miss_q + CNT_WIDTH'(1);
            victim_d = victim_sel;
            state_d  = victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          dataway_sel   = victim_q;
          pmem_addr_sel = victim_q ? 2'd2 : 2'd1;
          if (pmem_resp) state_d = ALLOCATE;
        end
        ALLOCATE: begin
          pmem_read   = 1'b1;
          dataway_sel = victim_q;
          if (pmem_resp) begin
            ld_data  = victim_q ? 2'b10 : 2'b01;
            ld_tag   = victim_q ? 2'b10 : 2'b01;
            ld_valid = victim_q ? 2'b10 : 2'b01;
            ld_dirty = victim_q ? 2'b10 : 2'b01;
            state_d  = req ? CHECK : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign {load_data1,  load_data0}  = ld_data;
  assign {load_tag1,   load_tag0}   = ld_tag;
  assign {load_valid1, load_valid0} = ld_valid;
  assign {load_dirty1, load_dirty0} = ld_dirty;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control with a one-set array model and a
// fixed-latency physical memory model.
module tb_cache_control;
  localparam int TW = 9;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, mem_read, mem_write, mem_resp;
  logic [1:0]    mem_byte_enable, pmem_addr_sel;
  logic [TW-1:0] addr_tag;
  logic          load_data0, load_data1, load_tag0, load_tag1, load_valid0, load_valid1;
  logic          load_dirty0, load_dirty1, load_lru, dirty_in, lru_in, datain_sel, dataway_sel;
  logic          pmem_read, pmem_write, pmem_resp;
  logic [CW-1:0] hit_count, miss_count;

  logic [TW-1:0] m_tag0, m_tag1, p_tag0, p_tag1;
  logic          m_v0, m_v1, m_d0, m_d1, m_lru, p_v0, p_v1, p_d0, p_d1, p_lru, preset_q;
  logic [1:0]    pcnt;
  logic          any_load;

  assign any_load = |{load_data0, load_data1, load_tag0, load_tag1, load_valid0, load_valid1,
                      load_dirty0, load_dirty1, load_lru};

  cache_control #(.TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp), .addr_tag(addr_tag),
    .tag0(m_tag0), .tag1(m_tag1), .valid0(m_v0), .valid1(m_v1), .dirty0(m_d0),
    .dirty1(m_d1), .lru(m_lru), .load_data0(load_data0), .load_data1(load_data1),
    .load_tag0(load_tag0), .load_tag1(load_tag1), .load_valid0(load_valid0),
    .load_valid1(load_valid1), .load_dirty0(load_dirty0), .load_dirty1(load_dirty1),
    .load_lru(load_lru), .dirty_in(dirty_in), .lru_in(lru_in), .datain_sel(datain_sel),
    .dataway_sel(dataway_sel), .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  // Array model: loaded from the bench preset or from the controller write enables.
  always @(posedge clk) begin
    if (preset_q) begin
      m_tag0 <= p_tag0; m_tag1 <= p_tag1; m_v0 <= p_v0; m_v1 <= p_v1;
      m_d0 <= p_d0; m_d1 <= p_d1; m_lru <= p_lru;
    end else begin
      if (load_tag0)   m_tag0 <= addr_tag;
      if (load_tag1)   m_tag1 <= addr_tag;
      if (load_valid0) m_v0 <= 1'b1;
      if (load_valid1) m_v1 <= 1'b1;
      if (load_dirty0) m_d0 <= dirty_in;
      if (load_dirty1) m_d1 <= dirty_in;
      if (load_lru)    m_lru <= lru_in;
    end
  end

  // Physical memory answers in the fourth cycle of each request.
  always @(posedge clk) begin
    if (pmem_resp || !(pmem_read || pmem_write)) begin
      pmem_resp <= 1'b0;
      pcnt      <= 2'd0;
    end else if (pcnt == 2'd2) begin
      pmem_resp <= 1'b1;
      pcnt      <= 2'd0;
    end else begin
      pcnt <= pcnt + 2'd1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int            lat;
    logic          way;
    logic          lru_in;
    logic          dsel;
    logic [1:0]    ldata;
    logic [1:0]    ldirty;
    logic [1:0]    vict;
    logic [1:0]    wbsel;
    logic [CW-1:0] hits;
    logic [CW-1:0] misses;
  } exp_t;

  exp_t          sbq[$];
  logic [CW-1:0] exp_hits = '0;
  logic [CW-1:0] exp_misses = '0;

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  task automatic preset(input logic [TW-1:0] t0, input logic [TW-1:0] t1, input logic v0,
                        input logic v1, input logic d0, input logic d1, input logic l);
    p_tag0 = t0; p_tag1 = t1; p_v0 = v0; p_v1 = v1; p_d0 = d0; p_d1 = d1; p_lru = l;
    preset_q = 1'b1;
    @(posedge clk); #1 preset_q = 1'b0;
  endtask

  task automatic run_req(input logic rd, input logic wr, input logic [1:0] be,
                         input logic [TW-1:0] t, input exp_t e);
    int   cyc;
    bit   done;
    exp_t x;
    sbq.push_back(e);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_byte_enable = be; addr_tag = t;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk); cyc++;
      check("pmem_exclusive", {31'd0, pmem_read & pmem_write}, 0);
      check("load_window", {31'd0, any_load & ~mem_resp & ~(pmem_read & pmem_resp)}, 0);
      if (pmem_write) check("wb_addr_sel", {30'd0, pmem_addr_sel}, {30'd0, e.wbsel});
      if (pmem_read)  check("alloc_addr_sel", {30'd0, pmem_addr_sel}, 0);
      if (pmem_read && pmem_resp) begin
        check("alloc_load_tag",   {30'd0, load_tag1, load_tag0}, {30'd0, e.vict});
        check("alloc_load_valid", {30'd0, load_valid1, load_valid0}, {30'd0, e.vict});
        check("alloc_load_data",  {30'd0, load_data1, load_data0}, {30'd0, e.vict});
        check("alloc_load_dirty", {30'd0, load_dirty1, load_dirty0}, {30'd0, e.vict});
        check("alloc_din_dsel",   {30'd0, dirty_in, datain_sel}, 0);
      end
      if (mem_resp) done = 1;
    end
    x = sbq.pop_front();
    if (!done) begin
      check("resp_timeout", 0, 1);
    end else begin
      check("latency",     cyc, x.lat);
      check("dataway_sel", {31'd0, dataway_sel}, {31'd0, x.way});
      check("load_lru",    {31'd0, load_lru}, 1);
      check("lru_in",      {31'd0, lru_in}, {31'd0, x.lru_in});
      check("datain_sel",  {31'd0, datain_sel}, {31'd0, x.dsel});
      check("hit_load_data",  {30'd0, load_data1, load_data0}, {30'd0, x.ldata});
      check("hit_load_dirty", {30'd0, load_dirty1, load_dirty0}, {30'd0, x.ldirty});
      check("hit_dirty_in",   {31'd0, dirty_in}, {31'd0, x.ldirty != 2'b00});
    end
    @(posedge clk); #1 mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("resp_one_cycle", {31'd0, mem_resp}, 0);
    check("hit_count",  {{(32-CW){1'b0}}, hit_count},  {{(32-CW){1'b0}}, x.hits});
    check("miss_count", {{(32-CW){1'b0}}, miss_count}, {{(32-CW){1'b0}}, x.misses});
  endtask

  function automatic exp_t mk(input int lat, input logic way, input logic li, input logic ds,
                              input logic [1:0] ld, input logic [1:0] ldt, input logic [1:0] vi,
                              input logic [1:0] wb);
    exp_t e;
    e.lat = lat; e.way = way; e.lru_in = li; e.dsel = ds; e.ldata = ld; e.ldirty = ldt;
    e.vict = vi; e.wbsel = wb; e.hits = exp_hits; e.misses = exp_misses;
    return e;
  endfunction

  task automatic wait_pmem_read(output bit seen);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pmem_read) seen = 1;
    end
    check("pmem_read_seen", {31'd0, seen}, 1);
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; mem_byte_enable = 2'b00;
    addr_tag = '0; preset_q = 1'b0; pmem_resp = 1'b0; pcnt = 2'd0;
    p_tag0 = '0; p_tag1 = '0; p_v0 = 0; p_v1 = 0; p_d0 = 0; p_d1 = 0; p_lru = 0;
    preset(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_mem_resp", {31'd0, mem_resp}, 0);
    check("rst_pmem", {30'd0, pmem_read, pmem_write}, 0);
    check("rst_loads", {31'd0, any_load}, 0);
    check("rst_misc", {27'd0, dirty_in, lru_in, datain_sel, dataway_sel, pmem_addr_sel}, 0);
    check("rst_counts", {{(32-2*CW){1'b0}}, hit_count, miss_count}, 0);
    mem_read = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    // Read hit in way0.
    preset(9'h05, 9'h00, 1, 0, 0, 0, 0);
    exp_hits = sat(exp_hits);
    run_req(1, 0, 2'b00, 9'h05, mk(2, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    // Write hit in way1 with a byte mask.
    preset(9'h10, 9'h33, 1, 1, 0, 0, 0);
    exp_hits = sat(exp_hits);
    run_req(0, 1, 2'b01, 9'h33, mk(2, 1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00));
    // Write hit with empty mask: LRU only.
    preset(9'h10, 9'h33, 1, 1, 0, 0, 1);
    exp_hits = sat(exp_hits);
    run_req(0, 1, 2'b00, 9'h10, mk(2, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    // Miss with dirty LRU victim way1: writeback then allocate.
    preset(9'h01, 9'h02, 1, 1, 0, 1, 1);
    exp_hits = sat(exp_hits); exp_misses = sat(exp_misses);
    run_req(1, 0, 2'b00, 9'h44, mk(11, 1, 0, 0, 2'b00, 2'b00, 2'b10, 2'd2));
    // Miss with invalid way0 (stale dirty bit ignored): allocate only.
    preset(9'h03, 9'h07, 0, 1, 1, 0, 1);
    exp_hits = sat(exp_hits); exp_misses = sat(exp_misses);
    run_req(1, 0, 2'b00, 9'h55, mk(7, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b00));
    // Read and write together behave as a write.
    preset(9'h20, 9'h21, 1, 1, 0, 0, 0);
    exp_hits = sat(exp_hits);
    run_req(1, 1, 2'b11, 9'h20, mk(2, 0, 1, 1, 2'b01, 2'b01, 2'b00, 2'b00));
    // Miss with dirty LRU victim way0.
    preset(9'h20, 9'h21, 1, 1, 1, 0, 0);
    exp_hits = sat(exp_hits); exp_misses = sat(exp_misses);
    run_req(1, 0, 2'b00, 9'h99, mk(11, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'd1));

    // Request dropped during allocate: finish pmem read, no response.
    preset(9'h03, 9'h07, 0, 1, 0, 0, 1);
    exp_misses = sat(exp_misses);
    @(posedge clk); #1 mem_read = 1'b1; addr_tag = 9'h77;
    wait_pmem_read(seen);
    @(posedge clk); #1 mem_read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("drop_no_resp", {31'd0, mem_resp}, 0);
    end
    check("drop_idle", {30'd0, pmem_read, pmem_write}, 0);
    check("drop_miss_count", {{(32-CW){1'b0}}, miss_count}, {{(32-CW){1'b0}}, exp_misses});

    // Reset pulse mid-allocate.
    preset(9'h03, 9'h07, 0, 1, 0, 0, 1);
    @(posedge clk); #1 mem_read = 1'b1; addr_tag = 9'h66;
    wait_pmem_read(seen);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_pmem_read", {31'd0, pmem_read}, 0);
    check("rstmid_loads", {31'd0, any_load}, 0);
    check("rstmid_counts", {{(32-2*CW){1'b0}}, hit_count, miss_count}, 0);
    mem_read = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    exp_hits = '0; exp_misses = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_idle", {29'd0, mem_resp, pmem_read, pmem_write}, 0);
    end
    check("rstmid_no_array_load", {22'd0, m_v0, m_tag0}, {22'd0, 1'b0, 9'h03});

    // Hit counter saturation.
    preset(9'h05, 9'h00, 1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      exp_hits = sat(exp_hits);
      run_req(1, 0, 2'b00, 9'h05, mk(2, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    end
    check("hit_saturated", {{(32-CW){1'b0}}, hit_count}, {{(32-CW){1'b0}}, {CW{1'b1}}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end
endmodule
